ofs_afu_irq_arb: RTL and testbench



---
 rtl/ofs_fim_cfg_pkg.sv | 17 +
 rtl/ofs_rr_pick.sv | 43 ++++
 rtl/ofs_afu_irq_arb.sv | 152 +++++++++++++++
 tb/tb_ofs_afu_irq_arb.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofs_fim_cfg_pkg.sv
// ofs_fim_cfg_pkg
//   FIM-wide configuration constants shared by the AFU-facing blocks.
//   NUM_AFUS / NUM_AFU_INTERRUPTS size the AFU interrupt fabric; the
//   AFU_IRQ_* constants give the flat MSI-X vector space seen by the
//   interrupt arbiter (one flat vector per AFU per interrupt id).
package ofs_fim_cfg_pkg;

    localparam int NUM_AFUS             = 2;
    localparam int NUM_AFU_INTERRUPTS   = 7;
    localparam int L_NUM_AFU_INTERRUPTS = 3;

    localparam int AFU_IRQ_NVEC = NUM_AFUS * NUM_AFU_INTERRUPTS;
    localparam int AFU_IRQ_VW   = (AFU_IRQ_NVEC > 1) ? $clog2(AFU_IRQ_NVEC) : 1;

    typedef logic [AFU_IRQ_VW-1:0] t_afu_irq_vec;

endpackage

// File: rtl/ofs_rr_pick.sv
// ofs_rr_pick
//   Combinational round-robin first-one finder. Searches req starting at
//   index ptr and moving upward, wrapping from NVEC-1 back to 0, and
//   reports the first set bit found.
// Ports:
//   req       in  NVEC  request bits
//   ptr       in  VW    search start index (0..NVEC-1)
//   gnt_valid out 1     at least one request bit is set
//   gnt_idx   out VW    index of the granted request (0 when none)
module ofs_rr_pick #(
    parameter int NVEC = 14,
    parameter int VW   = 4
) (
    input  logic [NVEC-1:0] req,
    input  logic [VW-1:0]   ptr,
    output logic            gnt_valid,
    output logic [VW-1:0]   gnt_idx
);

    localparam int unsigned N = NVEC;

    int unsigned   pos;
    logic [VW-1:0] idx;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        pos       = 0;
        idx       = '0;
        for (int unsigned i = 0; i < N; i++) begin
            pos = 32'(ptr) + i;
            if (pos >= N) begin
                pos = pos - N;
            end
            idx = VW'(pos);
            if (!gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/ofs_afu_irq_arb.sv
// ofs_afu_irq_arb
//   Collects one-cycle interrupt events from NUM_AFUS AFU ports into a
//   pending bit per flat vector (afu*NUM_IRQ + id), arbitrates unmasked
//   pending vectors round-robin into a single MSI-X request register, and
//   pulses a per-AFU acknowledge the cycle after the MSI-X block accepts.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   afu_irq_valid    in  NUM_AFUS       event strobe per AFU
//   afu_irq_id       in  NUM_AFUS*IDW   event id per AFU, AFU 0 in LSBs
//   afu_irq_ack      out NUM_AFUS       acknowledge pulse per AFU
//   afu_irq_ack_id   out NUM_AFUS*IDW   id being acknowledged per AFU
//   vec_mask         in  NVEC           1 = vector masked
//   msix_valid       out 1              request to MSI-X block
//   msix_vector      out VW             flat vector of the request
//   msix_ready       in  1              MSI-X block accepts the request
//   pba              out NVEC           pending bit array image
//   coalesce_cnt     out 16             saturating count of coalesced events
module ofs_afu_irq_arb
    import ofs_fim_cfg_pkg::*;
#(
    parameter  int NUM_AFUS = ofs_fim_cfg_pkg::NUM_AFUS,
    parameter  int NUM_IRQ  = ofs_fim_cfg_pkg::NUM_AFU_INTERRUPTS,
    parameter  int IDW      = ofs_fim_cfg_pkg::L_NUM_AFU_INTERRUPTS,
    localparam int NVEC     = NUM_AFUS * NUM_IRQ,
    localparam int VW       = (NVEC > 1) ? $clog2(NVEC) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_AFUS-1:0]     afu_irq_valid,
    input  logic [NUM_AFUS*IDW-1:0] afu_irq_id,
    output logic [NUM_AFUS-1:0]     afu_irq_ack,
    output logic [NUM_AFUS*IDW-1:0] afu_irq_ack_id,
    input  logic [NVEC-1:0]         vec_mask,
    output logic                    msix_valid,
    output logic [VW-1:0]           msix_vector,
    input  logic                    msix_ready,
    output logic [NVEC-1:0]         pba,
    output logic [15:0]             coalesce_cnt
);

    localparam int unsigned NIRQ_U = NUM_IRQ;
    localparam int unsigned NAFU_U = NUM_AFUS;

    logic [NVEC-1:0]         pending;
    logic [NVEC-1:0]         pending_n;
    logic [NVEC-1:0]         set_vec;
    logic [NVEC-1:0]         clr_vec;
    logic [VW-1:0]           rr;
    logic [VW-1:0]           rr_n;
    logic [15:0]             coal_inc;
    logic [16:0]             coal_sum;
    logic [15:0]             cnt_n;
    logic [IDW-1:0]          evt_id;
    logic [VW-1:0]           evt_vec;
    logic [NUM_AFUS-1:0]     ack_n;
    logic [NUM_AFUS*IDW-1:0] ack_id_n;
    int unsigned             ack_ofs;
    logic                    load_en;
    logic                    handshake;
    logic                    gnt_valid;
    logic [VW-1:0]           gnt_idx;

    assign pba       = pending;
    assign handshake = msix_valid & msix_ready;
    // Output register may take a new vector when empty or draining this cycle.
    assign load_en   = ~msix_valid | msix_ready;

    ofs_rr_pick #(
        .NVEC (NVEC),
        .VW   (VW)
    ) u_pick (
        .req       (pending & ~vec_mask),
        .ptr       (rr),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // Event decode: out-of-range ids are dropped; an event hitting a vector
    // that is pending or sitting in the output register is coalesced.
    always_comb begin
        set_vec  = '0;
        coal_inc = '0;
        evt_id   = '0;
        evt_vec  = '0;
        for (int unsigned a = 0; a < NAFU_U; a++) begin
            evt_id = afu_irq_id[a*IDW +: IDW];
            if (afu_irq_valid[a] && (32'(evt_id) < NIRQ_U)) begin
                evt_vec          = VW'(a * NIRQ_U + 32'(evt_id));
                set_vec[evt_vec] = 1'b1;
                if (pending[evt_vec] || (msix_valid && (msix_vector == evt_vec))) begin
                    coal_inc = coal_inc + 16'd1;
                end
            end
        end
    end

    always_comb begin
        coal_sum = {1'b0, coalesce_cnt} + {1'b0, coal_inc};
        cnt_n    = coal_sum[16] ? '1 : coal_sum[15:0];
    end

    // Clear and set are applied in that order so a same-cycle event wins.
    always_comb begin
        clr_vec = '0;
        rr_n    = rr;
        if (load_en && gnt_valid) begin
            clr_vec[gnt_idx] = 1'b1;
            rr_n = (32'(gnt_idx) == NVEC - 1) ? '0 : gnt_idx + VW'(1);
        end
        pending_n = (pending & ~clr_vec) | set_vec;
    end

    // Ack decode: the unsigned offset wraps to a huge value below an AFU's
    // base, so a single compare locates the owning AFU.
    always_comb begin
        ack_n    = '0;
        ack_id_n = '0;
        ack_ofs  = 0;
        for (int unsigned a = 0; a < NAFU_U; a++) begin
            ack_ofs = 32'(msix_vector) - a * NIRQ_U;
            if (handshake && (ack_ofs < NIRQ_U)) begin
                ack_n[a]                = 1'b1;
                ack_id_n[a*IDW +: IDW] = IDW'(ack_ofs);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending        <= '0;
            msix_valid     <= 1'b0;
            msix_vector    <= '0;
            rr             <= '0;
            afu_irq_ack    <= '0;
            afu_irq_ack_id <= '0;
            coalesce_cnt   <= '0;
        end else begin
            pending        <= pending_n;
            rr             <= rr_n;
            afu_irq_ack    <= ack_n;
            afu_irq_ack_id <= ack_id_n;
            coalesce_cnt   <= cnt_n;
            if (load_en) begin
                msix_valid <= gnt_valid;
                if (gnt_valid) begin
                    msix_vector <= gnt_idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_ofs_afu_irq_arb.sv
// tb_ofs_afu_irq_arb
//   Self-checking bench for ofs_afu_irq_arb with 2 AFUs x 7 vectors.
//   Table-driven directed vectors, hand-written multi-cycle sequences and
//   a randomized run against a behavioural reference model.
module tb_ofs_afu_irq_arb;

    localparam int NA = 2;
    localparam int NI = 7;
    localparam int IW = 3;
    localparam int NV = NA * NI;
    localparam int W  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NA-1:0]     afu_irq_valid;
    logic [NA*IW-1:0]  afu_irq_id;
    logic [NA-1:0]     afu_irq_ack;
    logic [NA*IW-1:0]  afu_irq_ack_id;
    logic [NV-1:0]     vec_mask;
    logic              msix_valid;
    logic [W-1:0]      msix_vector;
    logic              msix_ready;
    logic [NV-1:0]     pba;
    logic [15:0]       coalesce_cnt;

    always #5 clk = ~clk;

    ofs_afu_irq_arb #(
        .NUM_AFUS (NA),
        .NUM_IRQ  (NI),
        .IDW      (IW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .afu_irq_valid  (afu_irq_valid),
        .afu_irq_id     (afu_irq_id),
        .afu_irq_ack    (afu_irq_ack),
        .afu_irq_ack_id (afu_irq_ack_id),
        .vec_mask       (vec_mask),
        .msix_valid     (msix_valid),
        .msix_vector    (msix_vector),
        .msix_ready     (msix_ready),
        .pba            (pba),
        .coalesce_cnt   (coalesce_cnt)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [1:0] v, input logic [2:0] i0, input logic [2:0] i1,
                          input logic rdy);
        afu_irq_valid = v;
        afu_irq_id    = {i1, i0};
        msix_ready    = rdy;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        vec_mask = '0;
        set_in(2'b00, 3'd0, 3'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic check_outs(input string tag, input logic [13:0] e_pba, input logic e_valid,
                              input logic [3:0] e_vec, input logic [1:0] e_ack,
                              input logic [5:0] e_ack_id, input logic [15:0] e_cnt);
        logic [5:0] ai;
        ai = e_ack_id;
        chk({tag, ".pba"}, 32'(pba), 32'(e_pba));
        chk({tag, ".valid"}, 32'(msix_valid), 32'(e_valid));
        if (e_valid) chk({tag, ".vector"}, 32'(msix_vector), 32'(e_vec));
        chk({tag, ".ack"}, 32'(afu_irq_ack), 32'(e_ack));
        for (int a = 0; a < NA; a++) begin
            if (e_ack[a]) chk({tag, ".ack_id"}, 32'(afu_irq_ack_id[a*IW +: IW]), 32'(ai[a*IW +: IW]));
        end
        chk({tag, ".cnt"}, 32'(coalesce_cnt), 32'(e_cnt));
    endtask

    // Reference model: sets of pending vectors, one output slot, a
    // round-robin start index; selection uses modular arithmetic.
    bit [NV-1:0] mp;
    bit          mv;
    int          mvec;
    int          mrr;
    int          mcnt;
    logic [1:0]  m_ack;
    logic [5:0]  m_ackid;

    task automatic model_reset();
        mp = '0; mv = 1'b0; mvec = 0; mrr = 0; mcnt = 0; m_ack = '0; m_ackid = '0;
    endtask

    task automatic model_step();
        int setq[$];
        int id;
        int f;
        int sel;
        bit found;
        logic [2:0] idb;
        m_ack   = '0;
        m_ackid = '0;
        if (mv && msix_ready) begin
            idb = 3'(mvec % NI);
            m_ack[mvec / NI] = 1'b1;
            m_ackid[(mvec / NI)*IW +: IW] = idb;
        end
        for (int a = 0; a < NA; a++) begin
            id = int'(afu_irq_id[a*IW +: IW]);
            if (afu_irq_valid[a] && id < NI) begin
                f = a * NI + id;
                if (mp[f] || (mv && mvec == f)) mcnt = (mcnt >= 65535) ? 65535 : mcnt + 1;
                setq.push_back(f);
            end
        end
        if (!mv || msix_ready) begin
            found = 1'b0;
            sel   = 0;
            for (int k = 0; k < NV; k++) begin
                f = (mrr + k) % NV;
                if (!found && mp[f] && !vec_mask[f]) begin
                    found = 1'b1;
                    sel   = f;
                end
            end
            mv = found;
            if (found) begin
                mvec    = sel;
                mp[sel] = 1'b0;
                mrr     = (sel + 1) % NV;
            end
        end
        foreach (setq[j]) mp[setq[j]] = 1'b1;
    endtask

    typedef struct {
        logic [1:0]  v;
        logic [2:0]  id0;
        logic [2:0]  id1;
        logic        rdy;
        logic [13:0] e_pba;
        logic        e_valid;
        logic [3:0]  e_vec;
        logic [1:0]  e_ack;
        logic [5:0]  e_ack_id;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl[14];
    int   acks;

    initial begin
        // Consecutive cycles from reset; expected values are after the edge.
        tbl[0]  = '{2'b10, 3'd0, 3'd3, 1'b1, 14'h0400, 1'b0, 4'd0,  2'b00, 6'h00, 16'd0};
        tbl[1]  = '{2'b00, 3'd0, 3'd0, 1'b1, 14'h0000, 1'b1, 4'd10, 2'b00, 6'h00, 16'd0};
        tbl[2]  = '{2'b00, 3'd0, 3'd0, 1'b1, 14'h0000, 1'b0, 4'd0,  2'b10, 6'h18, 16'd0};
        tbl[3]  = '{2'b00, 3'd0, 3'd0, 1'b1, 14'h0000, 1'b0, 4'd0,  2'b00, 6'h00, 16'd0};
        tbl[4]  = '{2'b11, 3'd0, 3'd0, 1'b1, 14'h0081, 1'b0, 4'd0,  2'b00, 6'h00, 16'd0};
        tbl[5]  = '{2'b00, 3'd0, 3'd0, 1'b1, 14'h0080, 1'b1, 4'd0,  2'b00, 6'h00, 16'd0};
        tbl[6]  = '{2'b00, 3'd0, 3'd0, 1'b1, 14'h0000, 1'b1, 4'd7,  2'b01, 6'h00, 16'd0};
        tbl[7]  = '{2'b00, 3'd0, 3'd0, 1'b1, 14'h0000, 1'b0, 4'd0,  2'b10, 6'h00, 16'd0};
        tbl[8]  = '{2'b11, 3'd1, 3'd2, 1'b1, 14'h0202, 1'b0, 4'd0,  2'b00, 6'h00, 16'd0};
        tbl[9]  = '{2'b00, 3'd0, 3'd0, 1'b1, 14'h0002, 1'b1, 4'd9,  2'b00, 6'h00, 16'd0};
        tbl[10] = '{2'b00, 3'd0, 3'd0, 1'b1, 14'h0000, 1'b1, 4'd1,  2'b10, 6'h10, 16'd0};
        tbl[11] = '{2'b00, 3'd0, 3'd0, 1'b1, 14'h0000, 1'b0, 4'd0,  2'b01, 6'h01, 16'd0};
        tbl[12] = '{2'b01, 3'd7, 3'd0, 1'b1, 14'h0000, 1'b0, 4'd0,  2'b00, 6'h00, 16'd0};
        tbl[13] = '{2'b00, 3'd0, 3'd0, 1'b1, 14'h0000, 1'b0, 4'd0,  2'b00, 6'h00, 16'd0};

        do_reset();
        chk("reset.pba", 32'(pba), 32'd0);
        chk("reset.valid", 32'(msix_valid), 32'd0);
        chk("reset.vector", 32'(msix_vector), 32'd0);
        chk("reset.ack", 32'(afu_irq_ack), 32'd0);
        chk("reset.ack_id", 32'(afu_irq_ack_id), 32'd0);
        chk("reset.cnt", 32'(coalesce_cnt), 32'd0);

        for (int i = 0; i < 14; i++) begin
            set_in(tbl[i].v, tbl[i].id0, tbl[i].id1, tbl[i].rdy);
            tick();
            check_outs($sformatf("tbl%0d", i), tbl[i].e_pba, tbl[i].e_valid, tbl[i].e_vec,
                       tbl[i].e_ack, tbl[i].e_ack_id, tbl[i].e_cnt);
        end

        // Backpressure with coalescing on vector 2 over 20 stalled cycles.
        do_reset();
        set_in(2'b01, 3'd2, 3'd0, 1'b0); tick(); check_outs("bp0", 14'h0004, 1'b0, 4'd0, 2'b00, 6'h00, 16'd0);
        set_in(2'b00, 3'd0, 3'd0, 1'b0); tick(); check_outs("bp1", 14'h0000, 1'b1, 4'd2, 2'b00, 6'h00, 16'd0);
        set_in(2'b01, 3'd2, 3'd0, 1'b0); tick(); check_outs("bp2", 14'h0004, 1'b1, 4'd2, 2'b00, 6'h00, 16'd1);
        set_in(2'b01, 3'd2, 3'd0, 1'b0); tick(); check_outs("bp3", 14'h0004, 1'b1, 4'd2, 2'b00, 6'h00, 16'd2);
        set_in(2'b00, 3'd0, 3'd0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            tick();
            check_outs("bp_hold", 14'h0004, 1'b1, 4'd2, 2'b00, 6'h00, 16'd2);
        end
        acks = 0;
        set_in(2'b00, 3'd0, 3'd0, 1'b1);
        tick(); acks += int'(afu_irq_ack[0]);
        check_outs("bp_rel0", 14'h0000, 1'b1, 4'd2, 2'b01, 6'h02, 16'd2);
        tick(); acks += int'(afu_irq_ack[0]);
        check_outs("bp_rel1", 14'h0000, 1'b0, 4'd0, 2'b01, 6'h02, 16'd2);
        tick(); acks += int'(afu_irq_ack[0]);
        check_outs("bp_rel2", 14'h0000, 1'b0, 4'd0, 2'b00, 6'h00, 16'd2);
        chk("bp_ack_total", 32'(acks), 32'd2);

        // Masked vector stays pending until the mask drops.
        do_reset();
        vec_mask = 14'h0020;
        set_in(2'b01, 3'd5, 3'd0, 1'b1); tick(); check_outs("mk0", 14'h0020, 1'b0, 4'd0, 2'b00, 6'h00, 16'd0);
        set_in(2'b00, 3'd0, 3'd0, 1'b1);
        repeat (3) begin
            tick(); check_outs("mk_hold", 14'h0020, 1'b0, 4'd0, 2'b00, 6'h00, 16'd0);
        end
        vec_mask = '0;
        tick(); check_outs("mk_rel", 14'h0000, 1'b1, 4'd5, 2'b00, 6'h00, 16'd0);
        tick(); check_outs("mk_ack", 14'h0000, 1'b0, 4'd0, 2'b01, 6'h05, 16'd0);

        // Wrap from 13 to 0 and set/clear collision on vector 0.
        do_reset();
        set_in(2'b10, 3'd0, 3'd5, 1'b1); tick(); check_outs("wr0", 14'h1000, 1'b0, 4'd0, 2'b00, 6'h00, 16'd0);
        set_in(2'b00, 3'd0, 3'd0, 1'b1); tick(); check_outs("wr1", 14'h0000, 1'b1, 4'd12, 2'b00, 6'h00, 16'd0);
        tick(); check_outs("wr2", 14'h0000, 1'b0, 4'd0, 2'b10, 6'h28, 16'd0);
        set_in(2'b11, 3'd0, 3'd6, 1'b1); tick(); check_outs("wr3", 14'h2001, 1'b0, 4'd0, 2'b00, 6'h00, 16'd0);
        set_in(2'b00, 3'd0, 3'd0, 1'b1); tick(); check_outs("wr4", 14'h0001, 1'b1, 4'd13, 2'b00, 6'h00, 16'd0);
        set_in(2'b01, 3'd0, 3'd0, 1'b1); tick(); check_outs("wr_coll", 14'h0001, 1'b1, 4'd0, 2'b10, 6'h30, 16'd1);
        set_in(2'b00, 3'd0, 3'd0, 1'b1); tick(); check_outs("wr5", 14'h0000, 1'b1, 4'd0, 2'b01, 6'h00, 16'd1);
        tick(); check_outs("wr6", 14'h0000, 1'b0, 4'd0, 2'b01, 6'h00, 16'd1);
        tick(); check_outs("wr7", 14'h0000, 1'b0, 4'd0, 2'b00, 6'h00, 16'd1);

        // Asynchronous reset while a request is outstanding and work is pending.
        do_reset();
        set_in(2'b01, 3'd0, 3'd0, 1'b0); tick();
        set_in(2'b01, 3'd1, 3'd0, 1'b0); tick();
        check_outs("rs_pre", 14'h0002, 1'b1, 4'd0, 2'b00, 6'h00, 16'd0);
        set_in(2'b00, 3'd0, 3'd0, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        chk("rs_async.vector", 32'(msix_vector), 32'd0);
        chk("rs_async.ack_id", 32'(afu_irq_ack_id), 32'd0);
        check_outs("rs_async", 14'h0000, 1'b0, 4'd0, 2'b00, 6'h00, 16'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) begin
            tick(); check_outs("rs_after", 14'h0000, 1'b0, 4'd0, 2'b00, 6'h00, 16'd0);
        end

        // Coalesce counter saturation: two coalesced events per cycle.
        do_reset();
        set_in(2'b11, 3'd0, 3'd0, 1'b0);
        repeat (32768) @(posedge clk);
        #1;
        chk("sat.fffe", 32'(coalesce_cnt), 32'h0000fffe);
        tick(); chk("sat.ffff", 32'(coalesce_cnt), 32'h0000ffff);
        tick(); chk("sat.hold", 32'(coalesce_cnt), 32'h0000ffff);

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            set_in(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                   $urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) vec_mask = vec_mask ^ (14'd1 << $urandom_range(0, 13));
            model_step();
            tick();
            check_outs("rand", 14'(mp), mv, 4'(mvec), m_ack, m_ackid, 16'(mcnt));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
